event_order_serializer: RTL and testbench
=========================================

Name: event_order_serializer

Overview:
Collects single-cycle event strobes from two independent sources and stamps each with a free-running cycle timestamp. Emits the events one at a time on a valid/ready output in a deterministic order: oldest timestamp first, with a fixed tie-break for events stamped in the same cycle. It is the synthesizable consumer end of a same-time-step ordering problem and feeds the log/trace drain.

Parameters:
TS_W, 16, timestamp width in bits; the counter wraps at 2^TS_W.
DEPTH, 4, entries per source FIFO; must be a power of 2 and at least 2.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
s1_vld  in  1  source-1 event strobe; one event per high cycle; no backpressure
s2_vld  in  1  source-2 event strobe; same rules as s1_vld
s1_full  out  1  source-1 FIFO holds DEPTH entries (registered count)
s2_full  out  1  source-2 FIFO holds DEPTH entries (registered count)
m_vld  out  1  output event valid
m_rdy  in  1  downstream ready
m_src  out  1  0 = source 1, 1 = source 2
m_ts  out  TS_W  timestamp of the output event
ovf  out  1  sticky flag: an event was dropped
ts_now  out  TS_W  current timestamp counter

Behaviour:
- Reset (async, rstn=0):
  - ts_now, m_vld, m_src, m_ts, ovf, s1_full and s2_full are 0.
  - Both FIFOs are emptied.
  - Reset takes effect immediately, mid-transfer included; no stale event appears after release.
- Timestamp: ts_now increments by 1 every cycle out of reset and wraps from 2^TS_W-1 to 0.
- Capture:
  - sN_vld=1 in cycle C writes ts_now(C) into FIFO N at the edge ending C.
  - A write is accepted if count<DEPTH, or if count==DEPTH and the same edge pops FIFO N.
  - Otherwise the event is dropped and ovf is set. ovf clears only on reset.
- Output stage: one register holding m_vld/m_src/m_ts.
  - The register loads when m_vld=0, or when m_vld=1 and m_rdy=1 (a transfer).
  - It loads the selected FIFO head and pops that FIFO on the same edge.
- Selection when both heads are valid:
  - The head with the older timestamp wins.
  - Age compare is wrap-aware: a is older than b iff (b-a) mod 2^TS_W is non-zero and below 2^(TS_W-1).
  - Correct ordering requires that pending events differ in age by less than 2^(TS_W-1) cycles.
  - Equal timestamps: tie-break per the optional feature.
  - If only one head is valid, that head is selected.
- Latency: a strobe in cycle C, with an idle pipe, gives m_vld=1 in cycle C+2.
- Throughput: one event per cycle while m_rdy=1.
- Handshake: while m_vld=1 and m_rdy=0, m_src and m_ts are held stable.
- Simultaneous strobes: s1_vld and s2_vld may be high in the same cycle; both are captured with an identical timestamp.
- Per-source order: events from one source are emitted in arrival order.

Optional Feature:
SRC2_DEFER_EN
- Undefined: an equal-timestamp tie goes to source 2 (source 2 emitted first).
- Defined: source 2 is deferred on a tie, so source 1 is always emitted first among same-timestamp events.
- The macro affects only the tie-break. Latency, capacity and ovf behaviour are identical in both builds.

Test Plan:
- Reset release; s1_vld high in the cycle where ts_now=5; m_rdy=1. Required: m_vld=1 two cycles later with m_src=0, m_ts=5; m_vld=0 the next cycle.
- s1_vld and s2_vld both high at ts_now=5; m_rdy=1. Required, default build: (m_src=1, ts 5) then (m_src=0, ts 5) on consecutive cycles. Required, SRC2_DEFER_EN build: (0, 5) then (1, 5).
- m_rdy=0; s2 event at ts 3, then s1 event at ts 4; m_rdy raised at ts 10. Required: (1, 3) transferred first, then (0, 4); m_ts stable while m_rdy=0.
- DEPTH=4, m_rdy=0; s1_vld high for 6 consecutive cycles. Required:
  - 5 events held (1 in the output register, 4 in the FIFO); s1_full=1.
  - The 6th event is dropped; ovf=1 and stays set.
  - After draining: 5 events, timestamps strictly increasing by 1.
- TS_W=4, m_rdy=0; s1 event at ts 15, s2 event at ts 0 after the wrap. Required: output order (0, 15) then (1, 0).
- Events pending in both FIFOs with m_vld=1; rstn pulsed low mid-cycle. Required: m_vld=0, ovf=0, s1_full=0 and ts_now=0 immediately; no events emitted after release until new strobes arrive.

Source files
------------

// File: rtl/event_order_serializer.sv
// Two-source event serializer: stamps strobes with a free-running timestamp and emits oldest-first.
// Define SRC2_DEFER_EN to give source 1 priority on equal timestamps (default: source 2 wins ties).
module event_order_serializer #(
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s1_vld,
  input  logic            s2_vld,
  output logic            s1_full,
  output logic            s2_full,
  output logic            m_vld,
  input  logic            m_rdy,
  output logic            m_src,
  output logic [TS_W-1:0] m_ts,
  output logic            ovf,
  output logic [TS_W-1:0] ts_now
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [TS_W-1:0] mem1 [DEPTH];
  logic [TS_W-1:0] mem2 [DEPTH];
  logic [AW-1:0]   wp1, rp1, wp2, rp2;
  logic [CW-1:0]   cnt1, cnt2;

  logic            v1, v2, pick1, load;
  logic            pop1, pop2, wr1, wr2, drop1, drop2;
  logic [TS_W-1:0] head1, head2;

  // a is older than b when b-a (mod 2^TS_W) is non-zero and in the lower half-range
  function automatic logic older(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
    logic [TS_W-1:0] d;
    d = b - a;
    return (d != '0) && !d[TS_W-1];
  endfunction

  assign head1   = mem1[rp1];
  assign head2   = mem2[rp2];
  assign s1_full = (cnt1 == FULL_CNT);
  assign s2_full = (cnt2 == FULL_CNT);

  always_comb begin
    v1    = (cnt1 != '0);
    v2    = (cnt2 != '0);
    load  = !m_vld || m_rdy;
    pick1 = v1;
    if (v1 && v2) begin
`ifdef SRC2_DEFER_EN
      pick1 = !older(head2, head1);
`else
      pick1 = older(head1, head2);
`endif
    end
    pop1  = load && v1 && pick1;
    pop2  = load && v2 && !pick1;
    // a full FIFO still accepts when the same edge frees a slot
    wr1   = s1_vld && ((cnt1 != FULL_CNT) || pop1);
    wr2   = s2_vld && ((cnt2 != FULL_CNT) || pop2);
    drop1 = s1_vld && !wr1;
    drop2 = s2_vld && !wr2;
  end

  always_ff @(posedge clk) begin
    if (wr1) mem1[wp1] <= ts_now;
    if (wr2) mem2[wp2] <= ts_now;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_now <= '0;
      wp1    <= '0;
      rp1    <= '0;
      wp2    <= '0;
      rp2    <= '0;
      cnt1   <= '0;
      cnt2   <= '0;
      ovf    <= 1'b0;
      m_vld  <= 1'b0;
      m_src  <= 1'b0;
      m_ts   <= '0;
    end else begin
      ts_now <= ts_now + TS_W'(1);
      if (wr1)  wp1 <= wp1 + AW'(1);
      if (pop1) rp1 <= rp1 + AW'(1);
      if (wr2)  wp2 <= wp2 + AW'(1);
      if (pop2) rp2 <= rp2 + AW'(1);
      cnt1 <= cnt1 + CW'(wr1) - CW'(pop1);
      cnt2 <= cnt2 + CW'(wr2) - CW'(pop2);
      if (drop1 || drop2) ovf <= 1'b1;
      if (load) begin
        m_vld <= v1 || v2;
        if (v1 || v2) begin
          m_src <= !pick1;
          m_ts  <= pick1 ? head1 : head2;
        end
      end
    end
  end

endmodule

// File: tb/tb_event_order_serializer.sv
// Bench for event_order_serializer: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_event_order_serializer;

  localparam int unsigned TS_W  = 16;
  localparam int unsigned DEPTH = 4;
`ifdef SRC2_DEFER_EN
  localparam bit DEFER = 1'b1;
`else
  localparam bit DEFER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn;
  logic            s1, s2, rdy;
  logic            s1_full, s2_full, m_vld, m_src, ovf;
  logic [TS_W-1:0] m_ts, ts_now;

  logic       a1, a2, ardy;
  logic       a1_full, a2_full, a_vld, a_src, a_ovf;
  logic [3:0] a_ts, a_now;

  event_order_serializer #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .s1_vld(s1), .s2_vld(s2), .s1_full(s1_full), .s2_full(s2_full),
    .m_vld(m_vld), .m_rdy(rdy), .m_src(m_src), .m_ts(m_ts), .ovf(ovf), .ts_now(ts_now)
  );

  event_order_serializer #(.TS_W(4), .DEPTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .s1_vld(a1), .s2_vld(a2), .s1_full(a1_full), .s2_full(a2_full),
    .m_vld(a_vld), .m_rdy(ardy), .m_src(a_src), .m_ts(a_ts), .ovf(a_ovf), .ts_now(a_now)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    bit        rst;
    bit        s1;
    bit        s2;
    bit        rdy;
    bit        e_vld;
    bit        e_src;
    logic [15:0] e_ts;
    logic [15:0] e_now;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(bit rst, bit v1, bit v2, bit r, bit ev, bit es, int ets, int enow);
    vec_t v;
    v.rst = rst; v.s1 = v1; v.s2 = v2; v.rdy = r;
    v.e_vld = ev; v.e_src = es; v.e_ts = 16'(ets); v.e_now = 16'(enow);
    return v;
  endfunction

  // leaves the bench at a falling edge with reset just released (ts_now = 0 this cycle)
  task automatic apply_reset();
    rstn = 1'b0;
    s1 = 0; s2 = 0; rdy = 0; a1 = 0; a2 = 0; ardy = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // reference model state
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  bit          mv, msrc, movf;
  logic [15:0] mts, mnow;

  function automatic bit m_older(logic [15:0] a, logic [15:0] b);
    int d;
    d = (int'(b) - int'(a) + 65536) % 65536;
    return (d != 0) && (d < 32768);
  endfunction

  initial begin
    bit first_src;
    rstn = 1'b0;
    s1 = 0; s2 = 0; rdy = 0; a1 = 0; a2 = 0; ardy = 0;
    @(negedge clk);
    chk("rst_m_vld", m_vld, 0);
    chk("rst_m_src", m_src, 0);
    chk("rst_m_ts", m_ts, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_s1_full", s1_full, 0);
    chk("rst_s2_full", s2_full, 0);
    chk("rst_ts_now", ts_now, 0);

    // single event latency at ts 5
    tab.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, k));
    tab.push_back(mk(0, 1, 0, 1, 0, 0, 0, 5));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 6));
    tab.push_back(mk(0, 0, 0, 1, 1, 0, 5, 7));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8));
    // simultaneous strobes at ts 5
    first_src = DEFER ? 1'b0 : 1'b1;
    tab.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, k));
    tab.push_back(mk(0, 1, 1, 1, 0, 0, 0, 5));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 6));
    tab.push_back(mk(0, 0, 0, 1, 1, first_src, 5, 7));
    tab.push_back(mk(0, 0, 0, 1, 1, !first_src, 5, 8));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 9));
    // backpressure: s2@3, s1@4, ready from ts 10
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2));
    tab.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4));
    for (int k = 5; k <= 9; k++) tab.push_back(mk(0, 0, 0, 0, 1, 1, 3, k));
    tab.push_back(mk(0, 0, 0, 1, 1, 1, 3, 10));
    tab.push_back(mk(0, 0, 0, 1, 1, 0, 4, 11));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 12));

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].rst) apply_reset();
      else @(negedge clk);
      chk($sformatf("vec%0d_vld", i), m_vld, tab[i].e_vld);
      if (tab[i].e_vld) begin
        chk($sformatf("vec%0d_src", i), m_src, tab[i].e_src);
        chk($sformatf("vec%0d_ts", i), m_ts, tab[i].e_ts);
      end
      chk($sformatf("vec%0d_now", i), ts_now, tab[i].e_now);
      s1 = tab[i].s1; s2 = tab[i].s2; rdy = tab[i].rdy;
    end

    // overflow: six back-to-back s1 strobes with the output stalled
    apply_reset();
    rdy = 0; s1 = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) begin
        chk("ovf_full_before_drop", s1_full, 1);
        chk("ovf_clear_before_drop", ovf, 0);
      end
      if (k == 6) begin
        s1 = 0;
        chk("ovf_set", ovf, 1);
        chk("ovf_full", s1_full, 1);
        chk("ovf_head_vld", m_vld, 1);
        chk("ovf_head_ts", m_ts, 0);
      end
    end
    for (int k = 7; k <= 9; k++) begin
      @(negedge clk);
      chk("ovf_hold_ts", m_ts, 0);
      chk("ovf_sticky", ovf, 1);
    end
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      chk("drain_vld", m_vld, 1);
      chk("drain_src", m_src, 0);
      chk("drain_ts", m_ts, j);
      rdy = 1;
    end
    @(negedge clk);
    chk("drain_done", m_vld, 0);
    chk("drain_ovf_sticky", ovf, 1);
    chk("drain_not_full", s1_full, 0);

    // timestamp wrap on the 4-bit instance
    apply_reset();
    for (int k = 0; k <= 21; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0)  chk("w_now0", a_now, 0);
      if (k == 16) chk("w_now_wrap", a_now, 0);
      if (k == 17) begin chk("w_hold_vld", a_vld, 1); chk("w_hold_ts", a_ts, 12); end
      if (k == 18) begin chk("w_o1_vld", a_vld, 1); chk("w_o1_src", a_src, 1); chk("w_o1_ts", a_ts, 12); end
      if (k == 19) begin chk("w_o2_vld", a_vld, 1); chk("w_o2_src", a_src, 0); chk("w_o2_ts", a_ts, 15); end
      if (k == 20) begin chk("w_o3_vld", a_vld, 1); chk("w_o3_src", a_src, 1); chk("w_o3_ts", a_ts, 0); end
      if (k == 21) begin
        chk("w_done", a_vld, 0);
        chk("w_ovf", a_ovf, 0);
        chk("w_full1", a1_full, 0);
        chk("w_full2", a2_full, 0);
      end
      a1 = (k == 15);
      a2 = (k == 12) || (k == 16);
      ardy = (k >= 18);
    end

    // asynchronous reset with both FIFOs loaded and the output register valid
    apply_reset();
    rdy = 0; s1 = 1; s2 = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) s2 = 0;
      if (k == 6) s1 = 0;
    end
    chk("ar_pre_vld", m_vld, 1);
    chk("ar_pre_ovf", ovf, 1);
    chk("ar_pre_full", s1_full, 1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("ar_vld", m_vld, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_s1_full", s1_full, 0);
    chk("ar_s2_full", s2_full, 0);
    chk("ar_ts_now", ts_now, 0);
    @(negedge clk);
    rstn = 1'b1; rdy = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("ar_no_stale", m_vld, 0);
    end

    // randomized traffic against the reference model
    apply_reset();
    q1.delete(); q2.delete();
    mv = 0; msrc = 0; mts = '0; movf = 0; mnow = '0;
    for (int c = 0; c < 3000; c++) begin
      int pct_s, pct_r;
      bit ld;
      if (c > 0) @(negedge clk);
      chk("rnd_vld", m_vld, mv);
      if (mv) begin
        chk("rnd_src", m_src, msrc);
        chk("rnd_ts", m_ts, mts);
      end
      chk("rnd_ovf", ovf, movf);
      chk("rnd_full1", s1_full, q1.size() == DEPTH);
      chk("rnd_full2", s2_full, q2.size() == DEPTH);
      chk("rnd_now", ts_now, mnow);

      pct_s = (c < 1500) ? 25 : 60;
      pct_r = (c < 1500) ? 70 : 40;
      s1  = ($urandom_range(99) < pct_s);
      s2  = ($urandom_range(99) < pct_s);
      rdy = ($urandom_range(99) < pct_r);

      ld = !mv || rdy;
      if (ld) begin
        if (q1.size() > 0 && q2.size() > 0) begin
          bit take1;
          if (m_older(q1[0], q2[0]))      take1 = 1;
          else if (m_older(q2[0], q1[0])) take1 = 0;
          else                            take1 = DEFER;
          mv = 1; msrc = !take1;
          mts = take1 ? q1.pop_front() : q2.pop_front();
        end else if (q1.size() > 0) begin
          mv = 1; msrc = 0; mts = q1.pop_front();
        end else if (q2.size() > 0) begin
          mv = 1; msrc = 1; mts = q2.pop_front();
        end else begin
          mv = 0;
        end
      end
      if (s1) begin
        if (q1.size() < DEPTH) q1.push_back(mnow);
        else movf = 1;
      end
      if (s2) begin
        if (q2.size() < DEPTH) q2.push_back(mnow);
        else movf = 1;
      end
      mnow = mnow + 16'd1;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
